// File: rtl/bootloader.sv
`default_nettype none
// ============================================================================
// Module   : bootloader
// Purpose  : Receives a length-prefixed byte stream and writes it, as little-endian
//            words, into instruction memory. The core is released once loading ends.
//            Optional feature: define BOOTLOADER_CHECKSUM_EN to require a trailing
//            byte that equals the XOR of all payload bytes.
// Revision : 1.0 - initial release
// ============================================================================
module bootloader #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [3:0]  mem_w_enb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  output logic        core_rst,
  output logic        boot_done,
  output logic        boot_error
);

  // The index has one bit more than the memory needs, so it holds the
  // post-increment value after the last word without wrapping.
  localparam int          IDX_W    = ADDR_BITS - 1;
  localparam logic [31:0] CAPACITY = 32'd1 << (ADDR_BITS - 2);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
`ifdef BOOTLOADER_CHECKSUM_EN
    S_CHECK  = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

`ifdef BOOTLOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = S_CHECK;
`else
  localparam state_t AFTER_LAST = S_DONE;
`endif

  state_t           state;
  state_t           next_state;
  logic [7:0]       len_lo;
  logic [15:0]      n_words;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      word_buf;
`ifdef BOOTLOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic [31:0] assembled;
  logic        last_word;
  logic        ready_next;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {rx_data, len_lo};
  // The incoming byte lands in [31:24]; after four shifts the first byte sits in [7:0].
  assign assembled = {rx_data, word_buf[31:8]};
  assign last_word = ((32'(word_idx) + 32'd1) == 32'(n_words));

  always_comb begin
    next_state = state;
    case (state)
      S_LEN_LO: if (accept) next_state = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (32'(len_full) > CAPACITY)
            next_state = S_ERROR;
          else if (len_full == 16'd0)
            next_state = AFTER_LAST;
          else
            next_state = S_DATA;
        end
      end
      S_DATA:   if (accept && (byte_idx == 2'd3)) next_state = S_WRITE;
      S_WRITE:  next_state = last_word ? AFTER_LAST : S_DATA;
`ifdef BOOTLOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) next_state = (rx_data == csum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE:   next_state = S_DONE;
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_ERROR;
    endcase
  end

  always_comb begin
    ready_next = (next_state == S_LEN_LO) || (next_state == S_LEN_HI) ||
                 (next_state == S_DATA);
`ifdef BOOTLOADER_CHECKSUM_EN
    if (next_state == S_CHECK) ready_next = 1'b1;
`endif
  end

  // Outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN_LO;
      len_lo     <= 8'h00;
      n_words    <= 16'h0000;
      word_idx   <= '0;
      byte_idx   <= 2'd0;
      word_buf   <= 32'h0;
`ifdef BOOTLOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
      rx_ready   <= 1'b0;
      mem_w_enb  <= 4'h0;
      mem_addr   <= 32'h0;
      mem_w_data <= 32'h0;
      core_rst   <= 1'b1;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == S_LEN_LO) && accept) len_lo <= rx_data;
      if ((state == S_LEN_HI) && accept) n_words <= len_full;
      if ((state == S_DATA) && accept) begin
        word_buf <= assembled;
        byte_idx <= byte_idx + 2'd1;
`ifdef BOOTLOADER_CHECKSUM_EN
        csum     <= csum ^ rx_data;
`endif
      end
      if (state == S_WRITE) word_idx <= word_idx + IDX_W'(1);

      rx_ready  <= ready_next;
      mem_w_enb <= (next_state == S_WRITE) ? 4'hF : 4'h0;
      if (next_state == S_WRITE) begin
        mem_addr   <= 32'({word_idx, 2'b00});
        mem_w_data <= assembled;
      end
      core_rst   <= (next_state != S_DONE);
      boot_done  <= (next_state == S_DONE);
      boot_error <= (next_state == S_ERROR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bootloader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bootloader
// Purpose  : Directed self-checking bench for bootloader (default ADDR_BITS=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bootloader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [3:0]  mem_w_enb;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        core_rst;
  logic        boot_done;
  logic        boot_error;

  bootloader #(.ADDR_BITS(10)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_w_enb(mem_w_enb), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .core_rst(core_rst), .boot_done(boot_done),
    .boot_error(boot_error)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;
  int cyc = 0;
  int done_cyc = -1;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [3:0]  we[$];
  logic        wr[$];
  int          wc[$];

  always @(posedge clk) cyc++;

  // Write capture: one entry per cycle with any byte enable set.
  always @(negedge clk) begin
    if (mem_w_enb !== 4'h0) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_w_data);
      we.push_back(mem_w_enb);
      wr.push_back(rx_ready);
      wc.push_back(cyc);
    end
    if (core_rst === 1'b0 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered and left at a falling edge; the byte moves on the rising edge between.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk++;
      err++;
      $error("FAIL send_timeout observed=rx_ready_low expected=rx_ready_high byte=%h", b);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send(b);
    tick(1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    tick(2);
    wa.delete(); wd.delete(); we.delete(); wr.delete(); wc.delete();
    done_cyc = -1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(2);

    // Reset values
    check("rst_rx_ready",   32'(rx_ready),   32'd0);
    check("rst_mem_w_enb",  32'(mem_w_enb),  32'd0);
    check("rst_mem_addr",   mem_addr,        32'd0);
    check("rst_mem_w_data", mem_w_data,      32'd0);
    check("rst_core_rst",   32'(core_rst),   32'd1);
    check("rst_boot_done",  32'(boot_done),  32'd0);
    check("rst_boot_error", 32'(boot_error), 32'd0);

    // Two-word frame, back-to-back bytes
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
`ifdef BOOTLOADER_CHECKSUM_EN
    send(8'h90);
`endif
    tick(3);
    check("f1_nwrites", 32'(wa.size()), 32'd2);
    check("f1_addr0",   wa[0], 32'h0000_0000);
    check("f1_data0",   wd[0], 32'h0000_0013);
    check("f1_enb0",    32'(we[0]), 32'hF);
    check("f1_addr1",   wa[1], 32'h0000_0004);
    check("f1_data1",   wd[1], 32'h0010_0093);
    check("f1_enb1",    32'(we[1]), 32'hF);
`ifdef BOOTLOADER_CHECKSUM_EN
    check("f1_release_cycle", 32'(done_cyc), 32'(wc[1] + 2));
`else
    check("f1_release_cycle", 32'(done_cyc), 32'(wc[1] + 1));
`endif
    check("f1_boot_done",  32'(boot_done),  32'd1);
    check("f1_boot_error", 32'(boot_error), 32'd0);
    check("f1_core_rst",   32'(core_rst),   32'd0);

    // DONE ignores further traffic
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick(5);
    rx_valid = 1'b0;
    check("done_sticky",   32'(boot_done), 32'd1);
    check("done_rx_ready", 32'(rx_ready),  32'd0);
    check("done_nwrites",  32'(wa.size()), 32'd2);

`ifdef BOOTLOADER_CHECKSUM_EN
    // Bad checksum keeps the core in reset
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    send(8'h91);
    tick(2);
    check("bad_cs_error",    32'(boot_error), 32'd1);
    check("bad_cs_done",     32'(boot_done),  32'd0);
    check("bad_cs_core_rst", 32'(core_rst),   32'd1);
`endif

    // Same frame, rx_valid toggling every cycle
    do_reset();
    send_gap(8'h02); send_gap(8'h00);
    send_gap(8'h13); send_gap(8'h00); send_gap(8'h00); send_gap(8'h00);
    send_gap(8'h93); send_gap(8'h00); send_gap(8'h10); send_gap(8'h00);
`ifdef BOOTLOADER_CHECKSUM_EN
    send_gap(8'h90);
`endif
    tick(3);
    check("tg_nwrites", 32'(wa.size()), 32'd2);
    check("tg_addr0",   wa[0], 32'h0000_0000);
    check("tg_data0",   wd[0], 32'h0000_0013);
    check("tg_addr1",   wa[1], 32'h0000_0004);
    check("tg_data1",   wd[1], 32'h0010_0093);
    check("tg_ready_w0", 32'(wr[0]), 32'd0);
    check("tg_ready_w1", 32'(wr[1]), 32'd0);
    check("tg_boot_done", 32'(boot_done), 32'd1);

    // Oversized length (257 words > 256)
    do_reset();
    send(8'h01); send(8'h01);
    check("big_error_now", 32'(boot_error), 32'd1);
    check("big_rx_ready",  32'(rx_ready),   32'd0);
    tick(4);
    check("big_nwrites",   32'(wa.size()),  32'd0);
    check("big_core_rst",  32'(core_rst),   32'd1);

    // Exactly full memory (256 words) is accepted
    do_reset();
    send(8'h00); send(8'h01);
    check("cap_no_error", 32'(boot_error), 32'd0);
    check("cap_rx_ready", 32'(rx_ready),   32'd1);

    // Reset mid-frame, then a one-word frame restarts at address 0
    do_reset();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00);
    tick(1);
    check("mid_nwrites", 32'(wa.size()), 32'd1);
    do_reset();
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
`ifdef BOOTLOADER_CHECKSUM_EN
    send(8'h22);
`endif
    tick(3);
    check("rs_nwrites",   32'(wa.size()), 32'd1);
    check("rs_addr0",     wa[0], 32'h0000_0000);
    check("rs_data0",     wd[0], 32'hDEAD_BEEF);
    check("rs_boot_done", 32'(boot_done), 32'd1);

    // Empty image
    do_reset();
    send(8'h00); send(8'h00);
`ifdef BOOTLOADER_CHECKSUM_EN
    check("n0_wait_check", 32'(boot_done), 32'd0);
    send(8'h00);
`endif
    check("n0_boot_done", 32'(boot_done), 32'd1);
    check("n0_core_rst",  32'(core_rst),  32'd0);
    tick(2);
    check("n0_nwrites",   32'(wa.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
`default_nettype wire
